iommu_mem_arb_ctrl: RTL and testbench

- Ownership arbiter for the IOMMU implicit-memory AXI master port (`mem_req_o`/`mem_resp_i`).
- Shares the port between internal requesters: PTW, DDT/PDT walker, CQ fetch, FQ write, MSI/HPM writes.
- Grants exclusive ownership to one requester per transaction, round-robin, and releases on completion, withdrawal or watchdog timeout.
- The external AXI mux steers channels using `owner_o` while `busy_o` is high.

---
 rtl/iommu_mem_arb_ctrl_pkg.sv | 9 +
 rtl/iommu_mem_arb_ctrl_rr_pick.sv | 31 +++
 rtl/iommu_mem_arb_ctrl.sv | 129 ++++++++++++
 tb/tb_iommu_mem_arb_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/iommu_mem_arb_ctrl_pkg.sv
// rtl/iommu_mem_arb_ctrl_pkg.sv - shared types for the IOMMU memory-port arbiter
package rv_iommu;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/iommu_mem_arb_ctrl_rr_pick.sv
// rtl/iommu_mem_arb_ctrl_rr_pick.sv - combinational round-robin picker, first set bit at or after start
module iommu_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] sel
);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    sel   = start;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, start} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/iommu_mem_arb_ctrl.sv
// rtl/iommu_mem_arb_ctrl.sv - exclusive round-robin ownership arbiter for the IOMMU memory master port
module iommu_mem_arb_ctrl
  import rv_iommu::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     done_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [$clog2(N_REQ)-1:0] timeout_idx_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;
  logic [IDX_W-1:0] to_idx_q, to_idx_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_sel;
  logic             owner_req;
  logic             hit_limit;
  logic             release_now;
  logic             timeout_fire;

  iommu_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_i),
    .start (rr_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      to_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      to_idx_q <= to_idx_d;
    end
  end

  // Release priority: done, then withdrawal, then watchdog.
  always_comb begin
    owner_req    = req_i[owner_q];
    hit_limit    = (hold_q == CNT_W'(TIMEOUT_CYCLES - 1));
    release_now  = 1'b0;
    timeout_fire = 1'b0;
    state_d      = state_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = BUSY;
      end
      BUSY: begin
        release_now  = done_i || !owner_req || hit_limit;
        timeout_fire = !done_i && owner_req && hit_limit;
        if (release_now) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d   = hold_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    to_d     = 1'b0;
    to_idx_d = to_idx_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = N_REQ'(1) << pick_sel;
          owner_d = pick_sel;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (hold_q != {CNT_W{1'b1}}) hold_d = hold_q + 1'b1;
        if (release_now) begin
          gnt_d  = '0;
          busy_d = 1'b0;
          rr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        if (timeout_fire) begin
          to_d     = 1'b1;
          to_idx_d = owner_q;
        end
      end
      default: ;
    endcase
  end

  assign gnt_o         = gnt_q;
  assign owner_o       = owner_q;
  assign busy_o        = busy_q;
  assign timeout_o     = to_q;
  assign timeout_idx_o = to_idx_q;

endmodule

// File: tb/tb_iommu_mem_arb_ctrl.sv
// tb/tb_iommu_mem_arb_ctrl.sv - directed plus randomized bench for iommu_mem_arb_ctrl
module tb_iommu_mem_arb_ctrl;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] req_i = '0;
  logic         done_i = 1'b0;
  logic [N-1:0] gnt_o;
  logic [1:0]   owner_o;
  logic         busy_o;
  logic         timeout_o;
  logic [1:0]   timeout_idx_o;

  int checks = 0;
  int passed = 0;

  // Reference: who owns the port, for how long, and who is next in line.
  bit m_busy;
  int m_owner, m_age, m_rr, m_toidx;
  bit m_to;

  iommu_mem_arb_ctrl #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .done_i        (done_i),
    .gnt_o         (gnt_o),
    .owner_o       (owner_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .timeout_idx_o (timeout_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_tick(input bit r, input logic [N-1:0] q, input bit d);
    if (r) begin
      m_busy = 0; m_owner = 0; m_age = 0; m_rr = 0; m_to = 0; m_toidx = 0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (q[(m_rr + k) % N]) begin
          m_busy = 1; m_owner = (m_rr + k) % N; m_age = 0;
          break;
        end
      end
    end else if (d || !q[m_owner] || m_age == T - 1) begin
      if (!d && q[m_owner]) begin
        m_to = 1; m_toidx = m_owner;
      end
      m_busy = 0;
      m_rr = (m_owner + 1) % N;
    end else begin
      m_age++;
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] q, input bit d);
    @(negedge clk);
    rst_i = r; req_i = q; done_i = d;
    @(posedge clk);
    model_tick(r, q, d);
    #1;
    chk("model_gnt", gnt_o, m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("model_busy", busy_o, m_busy);
    chk("model_timeout", timeout_o, m_to);
    chk("model_timeout_idx", timeout_idx_o, m_toidx);
    if (m_busy) chk("model_owner", owner_o, m_owner);
  endtask

  initial begin
    int n;
    logic [N-1:0] rq;
    bit rd, rr;

    // Reset state
    step(1, 4'b0000, 0);
    chk("reset_gnt", gnt_o, 0);
    chk("reset_owner", owner_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_timeout", timeout_o, 0);

    // Single request and release latency
    step(0, 4'b0000, 0);
    step(0, 4'b0100, 0);
    chk("single_gnt", gnt_o, 4'b0100);
    chk("single_owner", owner_o, 2);
    chk("single_busy", busy_o, 1);
    step(0, 4'b0100, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b0100, 1);
    chk("single_release_gnt", gnt_o, 0);
    chk("single_release_busy", busy_o, 0);

    // Round-robin fairness with all requesting
    step(1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b1111, 0);
      chk("rr_owner", owner_o, i % N);
      chk("rr_busy", busy_o, 1);
      step(0, 4'b1111, 0);
      step(0, 4'b1111, 0);
      step(0, 4'b1111, 1);
      chk("rr_bubble", busy_o, 0);
    end

    // Wrap with sparse requests, pointer at 1
    step(1, 4'b0000, 0);
    step(0, 4'b0001, 0);
    step(0, 4'b0001, 1);
    step(0, 4'b1001, 0);
    chk("wrap_owner3", owner_o, 3);
    step(0, 4'b1001, 1);
    step(0, 4'b1001, 0);
    chk("wrap_owner0", owner_o, 0);

    // Watchdog on requester 1
    step(1, 4'b0000, 0);
    step(0, 4'b0001, 0);
    step(0, 4'b0001, 1);
    step(0, 4'b0110, 0);
    chk("wd_owner", owner_o, 1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 4'b0110, 0);
      if (timeout_o === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("wd_latency", n, T);
    chk("wd_gnt_low", gnt_o, 0);
    chk("wd_idx", timeout_idx_o, 1);
    step(0, 4'b0110, 0);
    chk("wd_pulse_end", timeout_o, 0);
    chk("wd_next_owner", owner_o, 2);

    // Done lands in the would-be timeout cycle
    for (int i = 0; i < T - 1; i++) step(0, 4'b0110, 0);
    step(0, 4'b0110, 1);
    chk("done_vs_to_timeout", timeout_o, 0);
    chk("done_vs_to_busy", busy_o, 0);

    // Withdrawal
    step(0, 4'b0110, 0);
    chk("wd2_owner", owner_o, 1);
    step(0, 4'b0100, 0);
    chk("withdraw_busy", busy_o, 0);
    chk("withdraw_timeout", timeout_o, 0);

    // Reset while busy
    step(0, 4'b0100, 0);
    chk("prerst_owner", owner_o, 2);
    step(1, 4'b0100, 0);
    chk("midrst_gnt", gnt_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_owner", owner_o, 0);
    step(0, 4'b1111, 0);
    chk("postrst_owner", owner_o, 0);

    // Randomized traffic
    rq = 4'b1111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      rd = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 149) == 0);
      step(rr, rq, rd);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
